// File: rtl/jk_cmd_debouncer.sv
// ---------------------------------------------------------------------------
// jk_cmd_debouncer
//
// Command stage that sits in front of the JK flip-flop block. Three raw
// pushbuttons (SET, CLR, TOG) are synchronised and debounced. Each accepted
// press turns into a single-cycle J/K command for the flip-flop. While no
// command is pending, J=K=0 so the flip-flop holds its state.
//
// Ports
//   CLK      in   system clock, rising edge
//   RST      in   synchronous active-high reset
//   BTN_SET  in   raw asynchronous button, active-high
//   BTN_CLR  in   raw asynchronous button, active-high
//   BTN_TOG  in   raw asynchronous button, active-high
//   J        out  registered J command (CLR: 0, SET: 1, TOG: 1)
//   K        out  registered K command (CLR: 1, SET: 0, TOG: 1)
//   DROP     out  one-cycle flag, a lower-priority request was discarded
//
// Parameters
//   DEB_CYCLES     consecutive stable cycles needed to accept a new level
//   CNT_W          debounce counter width, 2**CNT_W must exceed DEB_CYCLES
//   REPEAT_CYCLES  auto-repeat period, only meaningful with AUTO_REPEAT_EN
//
// Build option
//   AUTO_REPEAT_EN  when defined, a held TOG button re-issues the toggle
//                   command every REPEAT_CYCLES cycles after the first pulse.
// ---------------------------------------------------------------------------
module jk_cmd_debouncer #(
   parameter int DEB_CYCLES    = 4,
   parameter int CNT_W         = 3,
   parameter int REPEAT_CYCLES = 8
) (
   input  logic CLK,
   input  logic RST,
   input  logic BTN_SET,
   input  logic BTN_CLR,
   input  logic BTN_TOG,
   output logic J,
   output logic K,
   output logic DROP
);

   // Button index order, also the priority order (lowest index wins).
   localparam int IDX_CLR = 0;
   localparam int IDX_SET = 1;
   localparam int IDX_TOG = 2;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

   // Reject parameter sets the counters cannot represent.
   if (DEB_CYCLES < 2 || (1 << CNT_W) <= DEB_CYCLES || REPEAT_CYCLES < 1) begin : gBadParams
      $error("jk_cmd_debouncer: illegal parameter combination");
   end

   logic [2:0]       btnRaw;
   logic [2:0]       sync1;
   logic [2:0]       sync2;
   logic [2:0]       deb;
   logic [CNT_W-1:0] cnt [3];
   logic [2:0]       rise;
   logic [2:0]       req;
   logic             repFire;

   assign btnRaw = {BTN_TOG, BTN_SET, BTN_CLR};

   // A rise is flagged in the same cycle the debounced state is about to load
   // 0->1, so the command is registered on the very edge deb changes.
   always_comb begin
      rise = '0;
      for (int i = 0; i < 3; i++) begin
         rise[i] = sync2[i] && !deb[i] && (cnt[i] == DEB_LAST);
      end
   end

   // Two-flop synchroniser followed by a stability counter per button. Any
   // cycle where the synchronised level matches the debounced one (a bounce)
   // throws away the count collected so far.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         for (int i = 0; i < 3; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sync1 <= btnRaw;
         sync2 <= sync1;
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == DEB_LAST) begin
               deb[i] <= sync2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

`ifdef AUTO_REPEAT_EN
   localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

   logic [REP_W-1:0] repCnt;

   assign repFire = deb[IDX_TOG] && (repCnt == REP_LAST);

   // Repeat timer runs only while the debounced TOG level is high. It starts
   // from zero on the edge of the initial pulse, so the first repeat lands
   // exactly REPEAT_CYCLES edges later, whether or not it wins priority.
   always_ff @(posedge CLK) begin
      if (RST || !deb[IDX_TOG]) begin
         repCnt <= '0;
      end else if (repFire) begin
         repCnt <= '0;
      end else begin
         repCnt <= repCnt + REP_W'(1);
      end
   end
`else
   assign repFire = 1'b0;
`endif

   assign req = {rise[IDX_TOG] | repFire, rise[IDX_SET], rise[IDX_CLR]};

   // Output register. CLR beats SET beats TOG; any request that loses in
   // the same cycle raises DROP alongside the winning command.
   always_ff @(posedge CLK) begin
      if (RST) begin
         J    <= 1'b0;
         K    <= 1'b0;
         DROP <= 1'b0;
      end else begin
         J    <= !req[IDX_CLR] && (req[IDX_SET] || req[IDX_TOG]);
         K    <= req[IDX_CLR] || (!req[IDX_SET] && req[IDX_TOG]);
         DROP <= (req[IDX_CLR] && req[IDX_SET]) ||
                 (req[IDX_CLR] && req[IDX_TOG]) ||
                 (req[IDX_SET] && req[IDX_TOG]);
      end
   end

endmodule

// File: tb/tb_jk_cmd_debouncer.sv
// ---------------------------------------------------------------------------
// tb_jk_cmd_debouncer
//
// Self-checking bench for jk_cmd_debouncer. Directed scenarios (reset, clean
// press, bouncing press, simultaneous presses, reset during debounce, long
// hold) are followed by randomised bouncy button activity. A reference model
// describes each button as "the level seen two edges after it was driven
// must differ from the accepted level on DEB_CYCLES consecutive edges since
// the last acceptance", and derives J/K/DROP from the set of new presses.
// ---------------------------------------------------------------------------
module tb_jk_cmd_debouncer;

   localparam int DEB   = 4;
   localparam int CW    = 3;
   localparam int REP   = 8;
   localparam int HISTN = 64;

   logic clk;
   logic rst;
   logic btnSet;
   logic btnClr;
   logic btnTog;
   logic jOut;
   logic kOut;
   logic dropOut;

   int checks;
   int errors;

   // Model state
   int   edgeN;
   logic modelDeb   [3];
   logic delay1     [3];
   logic delay2     [3];
   int   lastFlip   [3];
   logic seenHist   [3][HISTN];
   int   lastTogIssue;
   logic expJ;
   logic expK;
   logic expDrop;

   // Directed-scenario bookkeeping
   int sinceMark;
   int firstPulseAt;
   int pulseCount;
   int dropCount;

   jk_cmd_debouncer #(
      .DEB_CYCLES(DEB),
      .CNT_W(CW),
      .REPEAT_CYCLES(REP)
   ) dut (
      .CLK(clk),
      .RST(rst),
      .BTN_SET(btnSet),
      .BTN_CLR(btnClr),
      .BTN_TOG(btnTog),
      .J(jOut),
      .K(kOut),
      .DROP(dropOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance the reference model by one rising edge using the inputs that
   // were stable at that edge.
   task automatic modelStep();
      logic [2:0] raw;
      logic [2:0] reqs;
      logic       togWasHigh;
      bit         accept;
      int         nReq;
      raw = {btnTog, btnSet, btnClr};
      edgeN++;
      if (rst) begin
         for (int b = 0; b < 3; b++) begin
            modelDeb[b] = 1'b0;
            delay1[b]   = 1'b0;
            delay2[b]   = 1'b0;
            lastFlip[b] = edgeN;
         end
         lastTogIssue = edgeN;
         expJ    = 1'b0;
         expK    = 1'b0;
         expDrop = 1'b0;
         return;
      end
      reqs       = '0;
      togWasHigh = modelDeb[2];
      for (int b = 0; b < 3; b++) begin
         seenHist[b][edgeN % HISTN] = delay2[b];
         accept = (edgeN - lastFlip[b] >= DEB);
         for (int k = 0; k < DEB; k++) begin
            if (seenHist[b][(edgeN - k) % HISTN] == modelDeb[b]) accept = 0;
         end
         if (accept) begin
            if (!modelDeb[b]) begin
               reqs[b] = 1'b1;
               if (b == 2) lastTogIssue = edgeN;
            end
            modelDeb[b] = !modelDeb[b];
            lastFlip[b] = edgeN;
         end
         delay2[b] = delay1[b];
         delay1[b] = raw[b];
      end
`ifdef AUTO_REPEAT_EN
      if (togWasHigh && (edgeN - lastTogIssue == REP)) begin
         reqs[2]      = 1'b1;
         lastTogIssue = edgeN;
      end
`else
      if (togWasHigh) lastTogIssue = edgeN;
`endif
      nReq = int'(reqs[0]) + int'(reqs[1]) + int'(reqs[2]);
      expDrop = (nReq > 1);
      if (reqs[0]) begin
         expJ = 1'b0; expK = 1'b1;
      end else if (reqs[1]) begin
         expJ = 1'b1; expK = 1'b0;
      end else if (reqs[2]) begin
         expJ = 1'b1; expK = 1'b1;
      end else begin
         expJ = 1'b0; expK = 1'b0;
      end
   endtask

   // Compare DUT outputs against the model, sampled 1 time unit after the edge.
   task automatic checkOutput(input string tag);
      checks++;
      assert ({jOut, kOut, dropOut} === {expJ, expK, expDrop})
      else begin
         errors++;
         $error("[TB] FAIL %s at edge %0d: J/K/DROP observed %b%b%b expected %b%b%b",
                tag, edgeN, jOut, kOut, dropOut, expJ, expK, expDrop);
      end
   endtask

   task automatic applyStimulus(input int cycles, input string tag);
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk);
         modelStep();
         #1;
         sinceMark++;
         if (jOut === 1'b1 || kOut === 1'b1) begin
            pulseCount++;
            if (firstPulseAt < 0) firstPulseAt = sinceMark;
         end
         if (dropOut === 1'b1) dropCount++;
         checkOutput(tag);
      end
   endtask

   task automatic markStart();
      sinceMark    = 0;
      firstPulseAt = -1;
      pulseCount   = 0;
      dropCount    = 0;
   endtask

   task automatic checkValue(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      edgeN  = 0;
      rst    = 1'b1;
      btnSet = 1'b0;
      btnClr = 1'b0;
      btnTog = 1'b0;
      markStart();

      // Reset held two cycles, then idle.
      applyStimulus(2, "reset");
      rst = 1'b0;
      applyStimulus(4, "idle");

      // Clean SET press: one J=1 K=0 pulse after edge 6.
      btnSet = 1'b1;
      markStart();
      applyStimulus(12, "setPress");
      checkValue("setPulseEdge", firstPulseAt, DEB + 2);
      checkValue("setPulseCount", pulseCount, 1);
      btnSet = 1'b0;
      applyStimulus(10, "setRelease");

      // Bouncing CLR for 10 cycles, then held high.
      for (int i = 0; i < 10; i++) begin
         btnClr = ~btnClr;
         applyStimulus(1, "clrBounce");
      end
      btnClr = 1'b1;
      markStart();
      applyStimulus(12, "clrHold");
      checkValue("clrPulseCount", pulseCount, 1);
      btnClr = 1'b0;
      applyStimulus(10, "clrRelease");

      // SET and TOG rise together: SET wins, DROP flags the lost TOG.
      btnSet = 1'b1;
      btnTog = 1'b1;
      markStart();
      applyStimulus(12, "setTogTogether");
      checkValue("setTogPulseCount", pulseCount, 1);
      checkValue("setTogDropCount", dropCount, 1);
      btnSet = 1'b0;
      btnTog = 1'b0;
      applyStimulus(10, "setTogRelease");

      // Reset arrives two cycles into a TOG debounce, button kept held.
      btnTog = 1'b1;
      applyStimulus(2, "togPreReset");
      rst = 1'b1;
      applyStimulus(2, "togInReset");
      rst = 1'b0;
      markStart();
      applyStimulus(10, "togAfterReset");
      checkValue("togAfterResetEdge", firstPulseAt, DEB + 2);
      checkValue("togAfterResetCount", pulseCount, 1);
      btnTog = 1'b0;
      applyStimulus(10, "togRelease");

      // Long TOG hold for 30 cycles, then release.
      btnTog = 1'b1;
      markStart();
      applyStimulus(30, "togLongHold");
      btnTog = 1'b0;
      applyStimulus(15, "togLongRelease");
`ifdef AUTO_REPEAT_EN
      checkValue("togRepeatCount", pulseCount, 4);
`else
      checkValue("togSingleCount", pulseCount, 1);
`endif

      // Random bouncy activity with occasional resets.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 11) == 0) btnSet = ~btnSet;
         if ($urandom_range(0, 11) == 0) btnClr = ~btnClr;
         if ($urandom_range(0, 11) == 0) btnTog = ~btnTog;
         rst = ($urandom_range(0, 149) == 0);
         applyStimulus(1, "random");
      end
      rst = 1'b0;
      applyStimulus(4, "randomTail");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
